// File: rtl/cv32e40x_div_ctrl.sv
// cv32e40x_div_ctrl: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Define CV32E40X_DIV_EARLY_EXIT_EN to skip the leading-zero iterations of the dividend.
module cv32e40x_div_ctrl #(
  parameter int DIV_W = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             kill_i,
  input  logic             enable_i,
  input  logic [1:0]       operator_i,
  input  logic [DIV_W-1:0] op_a_i,
  input  logic [DIV_W-1:0] op_b_i,
  input  logic             ex_ready_i,
  output logic [DIV_W-1:0] result_o,
  output logic             ready_o
);
  typedef enum logic [1:0] {IDLE, INIT, DIVIDE, DONE} state_e;
  state_e           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n, init_cnt;
  logic [DIV_W-1:0] a_q, a_n, b_q, b_n, rem_q, rem_n, quo_q, quo_n, div_q, div_n, res_q, res_n;
  logic [DIV_W-1:0] abs_a, abs_b, init_quo, step_rem, step_quo, step_val;
  logic [DIV_W:0]   sh;
  logic [1:0]       op_q, op_n;
  logic             neg_q, neg_n, sgn, rem_op, ovf, ge, zero_a;
  assign sgn      = ~op_q[0];
  assign rem_op   = op_q[1];
  assign abs_a    = (sgn & a_q[DIV_W-1]) ? -a_q : a_q;
  assign abs_b    = (sgn & b_q[DIV_W-1]) ? -b_q : b_q;
  assign ovf      = sgn & (a_q == {1'b1, {(DIV_W-1){1'b0}}}) & (&b_q);
  // 33-bit compare of the shifted partial remainder; the low 32 bits of the difference are exact when ge
  assign sh       = {rem_q, quo_q[DIV_W-1]};
  assign ge       = sh >= {1'b0, div_q};
  assign step_rem = ge ? sh[DIV_W-1:0] - div_q : sh[DIV_W-1:0];
  assign step_quo = {quo_q[DIV_W-2:0], ge};
  assign step_val = rem_op ? step_rem : step_quo;
`ifdef CV32E40X_DIV_EARLY_EXIT_EN
  function automatic logic [CNT_W-1:0] clz(input logic [DIV_W-1:0] v);
    clz = CNT_W'(DIV_W);
    for (int i = 0; i < DIV_W; i++)
      if (v[i]) clz = CNT_W'(DIV_W - 1 - i);
  endfunction
  logic [CNT_W-1:0] lz;
  assign lz       = clz(abs_a);
  assign init_cnt = CNT_W'(DIV_W) - lz;
  assign init_quo = abs_a << lz;
  assign zero_a   = abs_a == '0;
`else
  assign init_cnt = CNT_W'(DIV_W);
  assign init_quo = abs_a;
  assign zero_a   = 1'b0;
`endif
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    a_n     = a_q;
    b_n     = b_q;
    op_n    = op_q;
    rem_n   = rem_q;
    quo_n   = quo_q;
    div_n   = div_q;
    neg_n   = neg_q;
    res_n   = res_q;
    case (state_q)
      IDLE: if (enable_i && !kill_i) begin
        state_n = INIT;
        a_n     = op_a_i;
        b_n     = op_b_i;
        op_n    = operator_i;
      end
      INIT: begin
        cnt_n   = init_cnt;
        rem_n   = '0;
        quo_n   = init_quo;
        div_n   = abs_b;
        neg_n   = sgn & (rem_op ? a_q[DIV_W-1] : a_q[DIV_W-1] ^ b_q[DIV_W-1]);
        state_n = (b_q == '0 || ovf || zero_a) ? DONE : DIVIDE;
        if (b_q == '0) res_n = rem_op ? a_q : '1;
        else if (ovf) res_n = rem_op ? '0 : {1'b1, {(DIV_W-1){1'b0}}};
        else if (zero_a) res_n = '0;
      end
      DIVIDE: begin
        rem_n = step_rem;
        quo_n = step_quo;
        cnt_n = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_n = DONE;
          res_n   = neg_q ? -step_val : step_val;
        end
      end
      DONE: state_n = ex_ready_i ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
    if (kill_i) begin
      state_n = IDLE;
      cnt_n   = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      a_q     <= a_n;
      b_q     <= b_n;
      op_q    <= op_n;
      rem_q   <= rem_n;
      quo_q   <= quo_n;
      div_q   <= div_n;
      neg_q   <= neg_n;
      res_q   <= res_n;
    end
  end
  assign result_o = res_q;
  assign ready_o  = kill_i | (state_q == DONE) | ((state_q == IDLE) & ~enable_i);
endmodule
